// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
// Accepts one operand pair at a time. Completes in 33 cycles, one quotient bit
// per cycle, and returns {remainder, quotient} for the HI/LO write.
// Divide-by-zero returns 0 one cycle after the request.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_ON   = 2'b01,
    ST_END  = 2'b10
  } state_e;

  // Magnitude of a two's-complement value; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    abs32 = x[31] ? (~x + 32'd1) : x;
  endfunction

  // Two's-complement negation, used for final sign correction.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] divisor_q, divisor_d;
  // Working register: upper half holds the partial remainder, lower half
  // starts as the dividend and fills with quotient bits from the right.
  logic [63:0] partial_q, partial_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [32:0] upper_s;
  logic        take_s;
  logic [31:0] diff_s;
  logic [63:0] step_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // One restoring step. The shifted remainder needs 33 bits. The
  // subtraction only commits when the trial value is >= divisor, so its
  // 32-bit difference is exact.
  always_comb begin
    upper_s   = partial_q[63:31];
    take_s    = (upper_s >= {1'b0, divisor_q});
    diff_s    = upper_s[31:0] - divisor_q;
    if (take_s) begin
      step_s = {diff_s, partial_q[30:0], 1'b1};
    end else begin
      step_s = {upper_s[31:0], partial_q[30:0], 1'b0};
    end
    quo_fix_s = neg_quo_q ? neg32(step_s[31:0])  : step_s[31:0];
    rem_fix_s = neg_rem_q ? neg32(step_s[63:32]) : step_s[63:32];
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    partial_d = partial_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      ST_FREE: begin
        if (start && !annul) begin
          if (opdata2 == 32'd0) begin
            result_d = 64'd0;
            state_d  = ST_END;
          end else begin
            state_d   = ST_ON;
            cnt_d     = 5'd0;
            divisor_d = signed_div ? abs32(opdata2) : opdata2;
            partial_d = {32'd0, (signed_div ? abs32(opdata1) : opdata1)};
            neg_quo_d = signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem_d = signed_div & opdata1[31];
          end
        end else begin
          state_d = ST_FREE;
        end
      end
      ST_ON: begin
        if (annul) begin
          // Flush: drop the operation and keep the previous result.
          state_d = ST_FREE;
          cnt_d   = 5'd0;
        end else begin
          partial_d = step_s;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {rem_fix_s, quo_fix_s};
            state_d  = ST_END;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_END: begin
        // The result is already committed, so annul is ignored here.
        state_d = ST_FREE;
      end
      default: begin
        state_d = ST_FREE;
      end
    endcase

    ready_d = (state_d == ST_END);
    busy_d  = (state_d != ST_FREE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_FREE;
      cnt_q     <= 5'd0;
      divisor_q <= 32'd0;
      partial_q <= 64'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      partial_q <= partial_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit. Expected values are hand-computed.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a division at the current cycle (cycle 0) and wait for ready.
  // The operands are scrambled at cycle 3 to show they are sampled once.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output logic [63:0] res, output int busy_low);
    opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
    lat = -1; busy_low = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 3) begin
        opdata1 = ~a; opdata2 = b + 32'd5; signed_div = ~sgn;
      end
      if (ready) begin
        lat = c;
        break;
      end
      if (!busy) busy_low++;
    end
    res = result;
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    #2;
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 64'd0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_divu_basic;
    int lat; int bl; logic [63:0] res;
    do_div(32'd100, 32'd7, 1'b0, lat, res, bl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_result: got %h expected %h", res, 64'h00000002_0000000E); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL divu_busy_on: got %0d low cycles expected 0", bl); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL divu_ready_pulse: got %b expected 0", ready); end
    checks++; if (result !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_result_hold: got %h expected %h", result, 64'h00000002_0000000E); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_free_after: got %b expected 0", busy); end
  endtask

  task automatic test_signed_edges;
    logic [31:0] va [0:5];
    logic [31:0] vb [0:5];
    logic        vs [0:5];
    logic [63:0] ve [0:5];
    int lat; int bl; logic [63:0] res;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'h00000002; vs[0] = 1'b1; ve[0] = 64'hFFFFFFFF_FFFFFFFD;
    va[1] = 32'h00000007; vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1; ve[1] = 64'h00000001_FFFFFFFD;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vs[2] = 1'b1; ve[2] = 64'h00000000_80000000;
    va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000001; vs[3] = 1'b0; ve[3] = 64'h00000000_FFFFFFFF;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'h80000001; vs[4] = 1'b0; ve[4] = 64'h7FFFFFFE_00000001;
    va[5] = 32'hFFFFFF9C; vb[5] = 32'hFFFFFFF9; vs[5] = 1'b1; ve[5] = 64'hFFFFFFFE_0000000E;
    for (int i = 0; i < 6; i++) begin
      do_div(va[i], vb[i], vs[i], lat, res, bl);
      checks++; if (lat !== 33) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 33", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL vec%0d_result: got %h expected %h", i, res, ve[i]); end
      tick();
    end
  endtask

  task automatic test_div_zero;
    int lat; int bl; logic [63:0] res;
    for (int s = 0; s < 2; s++) begin
      do_div(32'h00001234, 32'd0, s[0], lat, res, bl);
      checks++; if (lat !== 1) begin errors++; $display("FAIL divzero%0d_latency: got %0d expected 1", s, lat); end
      checks++; if (res !== 64'd0) begin errors++; $display("FAIL divzero%0d_result: got %h expected 0", s, res); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divzero%0d_busy: got %b expected 0", s, busy); end
    end
  endtask

  task automatic test_annul;
    int lat; int bl; int pulses; logic [63:0] res;
    do_div(32'd1000, 32'd3, 1'b0, lat, res, bl);
    checks++; if (res !== 64'h00000001_0000014D) begin errors++; $display("FAIL annul_prior: got %h expected %h", res, 64'h00000001_0000014D); end
    tick();
    opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL annul_busy_on: got %b expected 1", busy); end
    annul = 1'b1; start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_free: got %b expected 0", busy); end
    annul = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d pulses expected 0", pulses); end
    checks++; if (result !== 64'h00000001_0000014D) begin errors++; $display("FAIL annul_result_kept: got %h expected %h", result, 64'h00000001_0000014D); end
    // annul in FREE blocks a start
    opdata1 = 32'd5; opdata2 = 32'd1; start = 1'b1; annul = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_free_block: got %b expected 0", busy); end
    start = 1'b0; annul = 1'b0;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_free_ready: got %b expected 0", ready); end
  endtask

  task automatic test_reset_mid;
    int lat; int bl; logic [63:0] res;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    #2 resetn = 1'b0;
    #1;
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
    start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_free: got %b expected 0", busy); end
    do_div(32'd9, 32'd2, 1'b0, lat, res, bl);
    checks++; if (lat !== 33 || res !== 64'h00000001_00000004) begin errors++; $display("FAIL rstmid_recover: got lat %0d res %h expected lat 33 res %h", lat, res, 64'h00000001_00000004); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat1; int lat2;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    lat1 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready) begin lat1 = c; break; end
    end
    checks++; if (lat1 !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", lat1); end
    checks++; if (result !== 64'h00000002_0000000E) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", result, 64'h00000002_0000000E); end
    tick();
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL b2b_free_cycle: got busy %b ready %b expected 0 0", busy, ready); end
    opdata1 = 32'h0000FFFF; opdata2 = 32'h00000010;
    lat2 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready) begin lat2 = c + 1; break; end
    end
    checks++; if (lat2 !== 34) begin errors++; $display("FAIL b2b_gap: got %0d expected 34", lat2); end
    checks++; if (result !== 64'h0000000F_00000FFF) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", result, 64'h0000000F_00000FFF); end
    start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_edges();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
